mem_responder: RTL and testbench

//  Memory-side responder for CPU load/store requests: accepts one request at a time over a valid/ready handshake.

---
 rtl/mem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder in front of a word-wide
// synchronous RAM. Adds programmable wait states and handles sub-word stores by
// read-modify-write. Each request produces exactly one single-cycle response.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned WORD_AW = ADDR_W - 2;
  localparam int unsigned DEPTH   = 1 << WORD_AW;
  localparam int unsigned CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_MERGE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;

  logic               write_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rmw_q;

  logic [31:0]        mem_q [DEPTH];

  logic               accept_c;
  logic               misalign_c;
  logic [WORD_AW-1:0] word_idx_c;
  logic [31:0]        ram_rd_c;
  logic [31:0]        load_lane_c;
  logic [31:0]        merge_c;
  logic               mem_we_c;
  logic [31:0]        mem_wdata_c;
  logic               unused_addr_c;

  assign accept_c      = req_valid & req_ready_q;
  assign word_idx_c    = addr_q[ADDR_W-1:2];
  assign ram_rd_c      = mem_q[word_idx_c];
  assign unused_addr_c = ^req_addr[31:ADDR_W];

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Alignment / reserved-size check on the incoming request.
  always_comb begin
    misalign_c = 1'b0;
    case (req_size)
      SZ_WORD: misalign_c = (req_addr[1:0] != 2'b00);
      SZ_HALF: misalign_c = req_addr[0];
      SZ_BYTE: misalign_c = 1'b0;
      default: misalign_c = 1'b1;
    endcase
  end

  // Select the addressed lane of the RAM word, zero-extended and right-aligned.
  always_comb begin
    load_lane_c = '0;
    case (size_q)
      SZ_WORD: load_lane_c = ram_rd_c;
      SZ_HALF: load_lane_c = addr_q[1] ? {16'h0, ram_rd_c[31:16]} : {16'h0, ram_rd_c[15:0]};
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    load_lane_c = {24'h0, ram_rd_c[7:0]};
          2'd1:    load_lane_c = {24'h0, ram_rd_c[15:8]};
          2'd2:    load_lane_c = {24'h0, ram_rd_c[23:16]};
          default: load_lane_c = {24'h0, ram_rd_c[31:24]};
        endcase
      end
      default: load_lane_c = '0;
    endcase
  end

  // Replace the addressed lane(s) of the previously read word with store data.
  always_comb begin
    merge_c = rmw_q;
    case (size_q)
      SZ_HALF: begin
        if (addr_q[1]) merge_c[31:16] = wdata_q[15:0];
        else           merge_c[15:0]  = wdata_q[15:0];
      end
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    merge_c[7:0]   = wdata_q[7:0];
          2'd1:    merge_c[15:8]  = wdata_q[7:0];
          2'd2:    merge_c[23:16] = wdata_q[7:0];
          default: merge_c[31:24] = wdata_q[7:0];
        endcase
      end
      default: merge_c = rmw_q;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_we_c     = 1'b0;
    mem_wdata_c  = wdata_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          req_ready_d = 1'b0;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          if (misalign_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!write_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_lane_c;
        end else if (size_q == SZ_WORD) begin
          mem_we_c     = 1'b1;
          mem_wdata_c  = wdata_q;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        mem_we_c     = 1'b1;
        mem_wdata_c  = merge_c;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Capture request fields on the accepting handshake.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      write_q <= req_write;
      size_q  <= req_size;
      addr_q  <= req_addr[ADDR_W-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Synchronous RAM read used by the read-modify-write path.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS) rmw_q <= ram_rd_c;
  end

  // RAM write port; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) mem_q[word_idx_c] <= mem_wdata_c;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (WAIT_CYCLES 0, 1, 3) share one
// request stream and are compared every cycle against a transaction-level model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  rdy, vld, err;
  logic [31:0] rd [3];

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[0]), .resp_rdata(rd[0]), .resp_err(err[0]));

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[1]), .resp_rdata(rd[1]), .resp_err(err[1]));

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[2]), .resp_rdata(rd[2]), .resp_err(err[2]));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          e = 0;
  bit          seen_reset = 0;

  // Model state per instance: memory image and the one in-flight transaction.
  logic [31:0] mem_m [3][64];
  bit          act [3];
  int          resp_e [3];
  int          wr_e [3];
  int          wr_idx [3];
  logic [31:0] wr_word [3];
  logic [31:0] exp_rd [3];
  bit          exp_err [3];

  // Last observed response per instance.
  int          last_re [3];
  logic [31:0] last_rd [3];
  logic        last_err [3];
  int          acc_e;

  function automatic int wait_of(int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
  endfunction

  function automatic bit is_err(logic [1:0] s, logic [31:0] a);
    if (s == 2'd3) return 1'b1;
    return (int'(a % 32'd4) % nbytes(s)) != 0;
  endfunction

  function automatic logic [63:0] lane_mask(logic [1:0] s);
    return (64'd1 << (8 * nbytes(s))) - 64'd1;
  endfunction

  function automatic logic [31:0] extract(logic [31:0] word, logic [1:0] s, logic [31:0] a);
    logic [63:0] w64;
    int sh;
    w64 = {32'd0, word};
    sh  = 8 * int'(a % 32'd4);
    return 32'((w64 >> sh) & lane_mask(s));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [1:0] s, logic [31:0] a);
    logic [63:0] o64, d64, m64;
    int sh;
    sh  = 8 * int'(a % 32'd4);
    o64 = {32'd0, old};
    d64 = {32'd0, wd};
    m64 = lane_mask(s) << sh;
    return 32'((o64 & ~m64) | ((d64 & lane_mask(s)) << sh));
  endfunction

  task automatic check(string nm, int i, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d edge=%0d: got %h want %h", nm, i, e, got, want);
    end
  endtask

  task automatic lit(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Model: advance every instance at each clock edge.
  initial begin
    bit was_idle;
    int w;
    int idx;
    for (int i = 0; i < 3; i++) act[i] = 1'b0;
    forever begin
      @(posedge clk);
      e = e + 1;
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          act[i] = 1'b0;
        end else begin
          was_idle = !act[i];
          if (act[i] && wr_e[i] == e) mem_m[i][wr_idx[i]] = wr_word[i];
          if (act[i] && e == resp_e[i] + 1) act[i] = 1'b0;
          if (was_idle && req_valid) begin
            w          = wait_of(i);
            idx        = int'(req_addr[7:2]);
            act[i]     = 1'b1;
            wr_e[i]    = -1;
            exp_rd[i]  = '0;
            exp_err[i] = 1'b0;
            if (is_err(req_size, req_addr)) begin
              resp_e[i]  = e;
              exp_err[i] = 1'b1;
            end else if (!req_write) begin
              resp_e[i] = e + w + 1;
              exp_rd[i] = extract(mem_m[i][idx], req_size, req_addr);
            end else if (req_size == 2'd0) begin
              resp_e[i]  = e + w + 1;
              wr_e[i]    = resp_e[i];
              wr_idx[i]  = idx;
              wr_word[i] = req_wdata;
            end else begin
              resp_e[i]  = e + w + 2;
              wr_e[i]    = resp_e[i];
              wr_idx[i]  = idx;
              wr_word[i] = merge(mem_m[i][idx], req_wdata, req_size, req_addr);
            end
          end
        end
      end
      if (reset) seen_reset = 1'b1;
    end
  end

  // Compare every instance against the model on each falling edge.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (vld[i] === 1'b1) begin
          last_re[i]  = e;
          last_rd[i]  = rd[i];
          last_err[i] = err[i];
        end
        if (seen_reset) begin
          ev = act[i] && (resp_e[i] == e);
          check("req_ready", i, 32'(rdy[i]), 32'(!act[i]));
          check("resp_valid", i, 32'(vld[i]), 32'(ev));
          if (ev) begin
            check("resp_rdata", i, rd[i], exp_rd[i]);
            check("resp_err", i, 32'(err[i]), 32'(exp_err[i]));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act[0] || act[1] || act[2]) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy want idle within 60 cycles");
    end
  endtask

  task automatic issue(bit w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    wait_idle();
    for (int i = 0; i < 3; i++) last_re[i] = -1;
    req_write = w;
    req_size  = s;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_e     = e;
    req_valid = 1'b0;
  endtask

  task automatic txn(bit w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    issue(w, s, a, d);
    wait_idle();
  endtask

  function automatic logic [31:0] lat(int i);
    return 32'(last_re[i] - acc_e + 1);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  // Directed checks followed by randomized traffic.
  initial begin
    bit          w;
    logic [1:0]  s;
    logic [31:0] a, d;
    int          k;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      lit("reset_ready", 32'(rdy[i]), 32'd1);
      lit("reset_valid", 32'(vld[i]), 32'd0);
      lit("reset_rdata", rd[i], 32'd0);
      lit("reset_err", 32'(err[i]), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 64; i++) txn(1'b1, 2'd0, 32'(i * 4), $urandom);

    // Word store then load, with per-instance latency.
    issue(1'b1, 2'd0, 32'h10, 32'hDEADBEEF);
    lit("busy_after_accept", 32'(rdy), 32'd0);
    wait_idle();
    lit("t1_store_lat", lat(1), 32'd3);
    lit("t1_store_rdata", last_rd[1], 32'd0);
    txn(1'b0, 2'd0, 32'h10, 32'h0);
    lit("t1_load_rdata", last_rd[1], 32'hDEADBEEF);
    lit("t1_load_err", 32'(last_err[1]), 32'd0);
    lit("t4_lat_w0", lat(0), 32'd2);
    lit("t4_lat_w1", lat(1), 32'd3);
    lit("t4_lat_w3", lat(2), 32'd5);

    // Byte store read-modify-write.
    txn(1'b1, 2'd2, 32'h12, 32'h00000055);
    lit("t2_bstore_lat", lat(1), 32'd4);
    txn(1'b0, 2'd0, 32'h10, 32'h0);
    lit("t2_word_load", last_rd[1], 32'hDE55BEEF);
    txn(1'b0, 2'd2, 32'h13, 32'h0);
    lit("t2_byte_load", last_rd[1], 32'h000000DE);

    // Error responses.
    txn(1'b0, 2'd1, 32'h11, 32'h0);
    lit("t3_half_mis_lat", lat(2), 32'd1);
    lit("t3_half_mis_err", 32'(last_err[2]), 32'd1);
    lit("t3_half_mis_rdata", last_rd[2], 32'd0);
    txn(1'b0, 2'd3, 32'h0, 32'h0);
    lit("t3_rsvd_err", 32'(last_err[0]), 32'd1);
    txn(1'b1, 2'd1, 32'h11, 32'hFFFFFFFF);
    txn(1'b1, 2'd0, 32'h12, 32'hFFFFFFFF);
    txn(1'b0, 2'd0, 32'h10, 32'h0);
    lit("t3_ram_unchanged", last_rd[1], 32'hDE55BEEF);

    // Address wrap.
    txn(1'b1, 2'd0, 32'h104, 32'hCAFEF00D);
    txn(1'b0, 2'd0, 32'h004, 32'h0);
    lit("t6_wrap", last_rd[1], 32'hCAFEF00D);

    // Reset during the MERGE state of the WAIT_CYCLES=1 instance.
    txn(1'b1, 2'd0, 32'h20, 32'h11223344);
    issue(1'b1, 2'd2, 32'h20, 32'h00000099);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lit("t5_ready_after_reset", 32'(rdy[1]), 32'd1);
    lit("t5_valid_after_reset", 32'(vld[1]), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    lit("t5_no_resp", 32'(last_re[1]), 32'hFFFFFFFF);
    txn(1'b0, 2'd0, 32'h20, 32'h0);
    lit("t5_word_kept_w1", last_rd[1], 32'h11223344);
    lit("t5_word_kept_w3", last_rd[2], 32'h11223344);
    lit("t5_word_merged_w0", last_rd[0], 32'h11223399);

    // Randomized traffic with occasional mid-transaction resets.
    repeat (300) begin
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
      d = $urandom;
      issue(w, s, a, d);
      if ($urandom_range(0, 29) == 0) begin
        k = $urandom_range(0, 5);
        repeat (k) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge clk); #1; end
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
